// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one uart_tx_path transmitter between N_REQ byte sources. Each grant
// latches the winner's byte, issues a one-cycle start strobe and then blocks
// further grants for one UART frame time (FRAME_CLKS cycles). When the frame
// time runs out and a request is already waiting, the next byte launches on
// that same edge, so back-to-back strobes are exactly FRAME_CLKS apart.
//
// Build option:
//   UART_TX_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins
//                              undefined -> round-robin from a rotating pointer
//
// Ports:
//   clk_i           system clock
//   rst_n_i         asynchronous active-low reset
//   req_valid_i     [N_REQ]    per-requester byte pending (held until acked)
//   req_data_i      [8*N_REQ]  byte of requester k on bits [8k+7:8k]
//   req_ack_o       [N_REQ]    one-cycle accept pulse, one-hot
//   uart_tx_data_o  [8]        registered byte toward uart_tx_path
//   uart_tx_en_o               one-cycle start strobe toward uart_tx_path
//   busy_o                     frame in progress
//   grant_id_o      [IDW]      index of the last granted requester
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int N_REQ      = 4,
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int FRAME_BITS = 10,
    localparam int IDW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [N_REQ-1:0]   req_valid_i,
    input  logic [8*N_REQ-1:0] req_data_i,
    output logic [N_REQ-1:0]   req_ack_o,
    output logic [7:0]         uart_tx_data_o,
    output logic               uart_tx_en_o,
    output logic               busy_o,
    output logic [IDW-1:0]     grant_id_o
);

    localparam int FRAME_CLKS = (CLK_FREQ / BAUD) * FRAME_BITS;
    localparam int CW         = (FRAME_CLKS > 2) ? $clog2(FRAME_CLKS) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(FRAME_CLKS - 1);

    generate
        if (FRAME_CLKS < 2) begin : g_bad_frame
            $error("uart_tx_arbiter: FRAME_CLKS must be >= 2");
        end
        if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
            $error("uart_tx_arbiter: N_REQ must be in 2..8");
        end
    endgenerate

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [IDW-1:0]     r_ptr;
    logic [7:0]         r_data;
    logic               r_en;
    logic [N_REQ-1:0]   r_ack;
    logic [IDW-1:0]     r_gid;

    logic               w_launch;
    logic [IDW-1:0]     w_win;
    logic [IDW-1:0]     w_next_ptr;
    logic [7:0]         w_byte;
    logic [N_REQ-1:0]   w_onehot;

    // (base + off) mod N_REQ without a divider; off is always < N_REQ.
    function automatic logic [IDW-1:0] rot_idx(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) s = s - N_REQ;
        return IDW'(s);
    endfunction

    // Scan offsets from the far end down so the closest set bit to the
    // pointer is the last one written and therefore wins.
    always_comb begin
        w_win = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid_i[rot_idx(r_ptr, i)]) w_win = rot_idx(r_ptr, i);
        end
    end

    always_comb begin
        w_byte = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (IDW'(k) == w_win) w_byte = req_data_i[8*k +: 8];
        end
    end

    assign w_onehot = N_REQ'(1) << w_win;

`ifdef UART_TX_ARB_FIXED_PRIO_EN
    // Pointer stays at zero, so the scan always starts from requester 0.
    assign w_next_ptr = '0;
`else
    assign w_next_ptr = rot_idx(w_win, 1);
`endif

    // A new frame may start from IDLE, or from WAIT on the edge the frame
    // counter has reached zero (r_cnt is held at 0 while IDLE).
    assign w_launch = (|req_valid_i) && ((r_state == ST_IDLE) || (r_cnt == '0));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_data  <= '0;
            r_en    <= 1'b0;
            r_ack   <= '0;
            r_gid   <= '0;
        end else begin
            r_en  <= 1'b0;
            r_ack <= '0;
            if (w_launch) begin
                r_data  <= w_byte;
                r_en    <= 1'b1;
                r_ack   <= w_onehot;
                r_gid   <= w_win;
                r_ptr   <= w_next_ptr;
                r_cnt   <= CNT_LOAD;
                r_state <= ST_WAIT;
            end else if (r_state == ST_WAIT) begin
                if (r_cnt == '0) begin
                    r_state <= ST_IDLE;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end

    assign req_ack_o      = r_ack;
    assign uart_tx_data_o = r_data;
    assign uart_tx_en_o   = r_en;
    assign busy_o         = (r_state == ST_WAIT);
    assign grant_id_o     = r_gid;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter with CLK_FREQ=1 MHz, BAUD=100 kHz,
// N_REQ=4, giving a 100-cycle frame. Inputs are driven and outputs sampled on
// the falling clock edge; the DUT acts on the rising edge.
// Honours UART_TX_ARB_FIXED_PRIO_EN for the two-requester arbitration step.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int FCK = 100;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_ack;
    logic [7:0]     tx_data;
    logic           tx_en;
    logic           busy;
    logic [1:0]     grant_id;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ      (N),
        .CLK_FREQ   (1000000),
        .BAUD       (100000),
        .FRAME_BITS (10)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .req_valid_i    (req_valid),
        .req_data_i     (req_data),
        .req_ack_o      (req_ack),
        .uart_tx_data_o (tx_data),
        .uart_tx_en_o   (tx_en),
        .busy_o         (busy),
        .grant_id_o     (grant_id)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Steps until a start strobe is seen; cyc = budget+1 on timeout.
    task automatic wait_en(input int budget, output int cyc, output bit dropped);
        cyc = 0;
        dropped = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            cyc++;
            if (tx_en) return;
            if (!busy) dropped = 1'b1;
        end
        cyc = budget + 1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc;
        int  n;
        int  ens;
        int  acks;
        bit  drp;
        logic [1:0] exp_g [5];

        // Reset state
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        step();
        chk("rst_data",  tx_data,  0);
        chk("rst_en",    tx_en,    0);
        chk("rst_ack",   req_ack,  0);
        chk("rst_busy",  busy,     0);
        chk("rst_grant", grant_id, 0);
        step();
        rst_n = 1'b1;

        // 1: single requester 0, byte 0x55
        req_data  = 32'h0000_0055;
        req_valid = 4'b0001;
        wait_en(10, cyc, drp);
        chk("t1_latency", cyc, 1);
        chk("t1_data",  tx_data,  8'h55);
        chk("t1_ack",   req_ack,  4'b0001);
        chk("t1_grant", grant_id, 0);
        chk("t1_busy",  busy,     1);
        req_valid = '0;
        n   = 1;
        ens = 0;
        acks = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (!busy) break;
            n++;
            if (tx_en) ens++;
            if (req_ack != 0) acks++;
        end
        chk("t1_busy_len",  n,    FCK);
        chk("t1_extra_en",  ens,  0);
        chk("t1_extra_ack", acks, 0);
        chk("t1_data_hold", tx_data,  8'h55);
        chk("t1_gid_hold",  grant_id, 0);

        // 2: all four requesting, round robin 0,1,2,3,0
        do_reset();
        req_data  = 32'hA3A2_A1A0;
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_en(150, cyc, drp);
            chk($sformatf("t2_spacing%0d", k), cyc, (k == 0) ? 1 : FCK);
            chk($sformatf("t2_grant%0d", k), grant_id, k % 4);
            chk($sformatf("t2_data%0d", k),  tx_data,  8'hA0 + (k % 4));
            chk($sformatf("t2_ack%0d", k),   req_ack,  4'b0001 << (k % 4));
        end

        // 3: req 2 alone, req 1 joins at cycle 30 of the frame
        do_reset();
        req_data  = 32'h0033_1100;
        req_valid = 4'b0100;
        wait_en(10, cyc, drp);
        chk("t3_grant_a", grant_id, 2);
        chk("t3_data_a",  tx_data,  8'h33);
        req_valid = '0;
        for (int i = 1; i < 30; i++) step();
        req_valid = 4'b0010;
        wait_en(150, cyc, drp);
        chk("t3_spacing", 29 + cyc, FCK);
        chk("t3_busy_gap", drp, 0);
        chk("t3_grant_b", grant_id, 1);
        chk("t3_data_b",  tx_data,  8'h11);
        chk("t3_ack_b",   req_ack,  4'b0010);
        req_valid = '0;

        // 4: asynchronous reset in the middle of a frame
        do_reset();
        req_data  = 32'h7700_0000;
        req_valid = 4'b1000;
        wait_en(10, cyc, drp);
        chk("t4_grant_pre", grant_id, 3);
        req_data = 32'h7800_0000;
        for (int i = 1; i < 40; i++) step();
        chk("t4_busy_pre", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t4_async_data",  tx_data,  0);
        chk("t4_async_grant", grant_id, 0);
        chk("t4_async_busy",  busy,     0);
        chk("t4_async_en",    tx_en,    0);
        chk("t4_async_ack",   req_ack,  0);
        step();
        rst_n = 1'b1;
        wait_en(10, cyc, drp);
        chk("t4_relaunch", cyc, 1);
        chk("t4_grant",    grant_id, 3);
        chk("t4_data",     tx_data,  8'h78);
        chk("t4_ack",      req_ack,  4'b1000);
        req_valid = '0;

        // 5: requesters 0 and 3 both valid for five frames
        do_reset();
`ifdef UART_TX_ARB_FIXED_PRIO_EN
        exp_g = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`else
        exp_g = '{2'd0, 2'd3, 2'd0, 2'd3, 2'd0};
`endif
        req_data  = 32'hC300_00C0;
        req_valid = 4'b1001;
        for (int k = 0; k < 5; k++) begin
            wait_en(150, cyc, drp);
            chk($sformatf("t5_spacing%0d", k), cyc, (k == 0) ? 1 : FCK);
            chk($sformatf("t5_grant%0d", k), grant_id, exp_g[k]);
            chk($sformatf("t5_data%0d", k),  tx_data,  (exp_g[k] == 0) ? 8'hC0 : 8'hC3);
        end
        req_valid = 4'b1000;
        wait_en(150, cyc, drp);
        chk("t5_last_spacing", cyc, FCK);
        chk("t5_last_grant",   grant_id, 3);
        chk("t5_last_ack",     req_ack,  4'b1000);
        req_valid = '0;

        // 6: one-cycle request during WAIT is forgotten
        do_reset();
        req_data  = 32'h0022_1100;
        req_valid = 4'b0100;
        wait_en(10, cyc, drp);
        chk("t6_grant_a", grant_id, 2);
        req_valid = '0;
        for (int i = 0; i < 10; i++) step();
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        ens  = 0;
        acks = 0;
        for (int i = 0; i < 150; i++) begin
            step();
            if (tx_en) ens++;
            if (req_ack != 0) acks++;
        end
        chk("t6_no_en",   ens,  0);
        chk("t6_no_ack",  acks, 0);
        chk("t6_idle",    busy, 0);
        chk("t6_gid_hold", grant_id, 2);
        chk("t6_data_hold", tx_data, 8'h22);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
